// File: rtl/cplx_scaled_adder.sv
// cplx_scaled_adder: two-stage handshaked complex add/subtract for the
// radix-4 FFT butterfly lanes. S1 holds the full-precision DATA_W+1 bit
// sum/difference; S2 applies the optional /2 scale, saturates and drives
// the outputs together with the overflow flag.
//
// Build option: define CSA_ROUND_EN for round-half-up on scaled results;
// otherwise scaled results are truncated (floor) and can never clamp.
module cplx_scaled_adder #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          OVF_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic              scale,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] s_re,
  output logic [DATA_W-1:0] s_im,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int unsigned SW = DATA_W + 1;  // full-precision sum width
  localparam int unsigned RW = DATA_W + 2;  // headroom for the rounding add

  // Sign-extended add or subtract; DATA_W+1 bits can never wrap.
  function automatic logic [SW-1:0] add_sub(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic              sub);
    logic [SW-1:0] ae;
    logic [SW-1:0] be;
    ae = {a[DATA_W-1], a};
    be = {b[DATA_W-1], b};
    return sub ? (ae - be) : (ae + be);
  endfunction

  // Scale, round and saturate one component. Returns {clamp, value}.
  function automatic logic [DATA_W:0] scale_sat(input logic [SW-1:0] sum,
                                                 input logic          sc);
    logic [RW-1:0]     ext;
    logic [RW-1:0]     rr;
    logic [RW-1:0]     r;
    logic              clamp;
    logic [DATA_W-1:0] val;
    ext = {sum[SW-1], sum};
`ifdef CSA_ROUND_EN
    // The +1 can push a-b = 2^DW-1 up to 2^DW, which is why RW has a spare bit.
    rr = ext + RW'(1);
`else
    rr = ext;
`endif
    if (sc) begin
      r = {rr[RW-1], rr[RW-1:1]};
    end else begin
      r = ext;
    end
    // In range only when every bit from the result MSB upward agrees.
    clamp = !((&r[RW-1:DATA_W-1]) || !(|r[RW-1:DATA_W-1]));
    if (clamp) begin
      val = r[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      val = r[DATA_W-1:0];
    end
    return {clamp, val};
  endfunction

  logic              s1_valid_q;
  logic [SW-1:0]     s1_re_q;
  logic [SW-1:0]     s1_im_q;
  logic              s1_scale_q;
  logic [SW-1:0]     s1_re_d;
  logic [SW-1:0]     s1_im_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] s_re_q;
  logic [DATA_W-1:0] s_im_q;
  logic [DATA_W-1:0] s_re_d;
  logic [DATA_W-1:0] s_im_d;
  logic              clamp_re_d;
  logic              clamp_im_d;
  logic              clamp_d;
  logic              ovf_q;
  logic              ovf_d;

  logic              s2_load;
  logic              s1_load;

  // Backpressure: a stage may load when it is empty or its content leaves.
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  // Stage 1 datapath: full-precision sum/difference of each component.
  always_comb begin
    s1_re_d = add_sub(a_re, b_re, op_sub);
    s1_im_d = add_sub(a_im, b_im, op_sub);
  end

  // Stage 2 datapath: scale/round/saturate, re and im independently.
  always_comb begin
    {clamp_re_d, s_re_d} = scale_sat(s1_re_q, s1_scale_q);
    {clamp_im_d, s_im_d} = scale_sat(s1_im_q, s1_scale_q);
    clamp_d = clamp_re_d || clamp_im_d;
  end

  // Overflow flag next state; a new clamp beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (OVF_STICKY) begin
      if (s2_load && s1_valid_q && clamp_d) begin
        ovf_d = 1'b1;
      end else if (clr_ovf) begin
        ovf_d = 1'b0;
      end
    end else begin
      // Pulse mode: follows whatever S2 holds, and a bubble clears it.
      if (s2_load) begin
        ovf_d = s1_valid_q && clamp_d;
      end
    end
  end

  // Stage 1 register: capture the accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_scale_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_re_q    <= s1_re_d;
        s1_im_q    <= s1_im_d;
        s1_scale_q <= scale;
      end
    end
  end

  // Stage 2 register: outputs hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_re_q      <= '0;
      s_im_q      <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s_re_q <= s_re_d;
        s_im_q <= s_im_d;
      end
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s_re      = s_re_q;
  assign s_im      = s_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cplx_scaled_adder.sv
// Directed bench for cplx_scaled_adder. Two instances share the inputs:
// u_dut uses the sticky overflow flag, u_dut_ns the per-result pulse flag.
module tb_cplx_scaled_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        op_sub;
  logic        scale;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic        out_ready;
  logic        clr_ovf;

  logic        in_ready, out_valid, ovf;
  logic [31:0] s_re, s_im;
  logic        in_ready_ns, out_valid_ns, ovf_ns;
  logic [31:0] s_re_ns, s_im_ns;

  int n_checks = 0;
  int n_err    = 0;

  cplx_scaled_adder #(.DATA_W(32), .OVF_STICKY(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .scale(scale), .a_re(a_re), .a_im(a_im),
    .b_re(b_re), .b_im(b_im), .out_valid(out_valid), .out_ready(out_ready),
    .s_re(s_re), .s_im(s_im), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  cplx_scaled_adder #(.DATA_W(32), .OVF_STICKY(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ns),
    .op_sub(op_sub), .scale(scale), .a_re(a_re), .a_im(a_im),
    .b_re(b_re), .b_im(b_im), .out_valid(out_valid_ns), .out_ready(out_ready),
    .s_re(s_re_ns), .s_im(s_im_ns), .ovf(ovf_ns), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic sub, input logic sc,
                        input logic [31:0] ar, input logic [31:0] ai,
                        input logic [31:0] br, input logic [31:0] bi);
    op_sub = sub; scale = sc;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
  endtask

  // Present one input for a single accepting edge.
  task automatic send(input logic sub, input logic sc,
                      input logic [31:0] ar, input logic [31:0] ai,
                      input logic [31:0] br, input logic [31:0] bi);
    set_in(sub, sc, ar, ai, br, bi);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int got;
    logic held_v;
    logic [31:0] held_re, held_im;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    #12;
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_s_re", s_re, 32'd0);
    check32("rst_s_im", s_im, 32'd0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Scaled add: 137/2 and -7/2.
    send(1'b0, 1'b1, 32'd100, -32'sd5, 32'd37, -32'sd2);
    check1("lat_cycle1_out_valid", out_valid, 1'b0);
    step();
    check1("lat_cycle2_out_valid", out_valid, 1'b1);
`ifdef CSA_ROUND_EN
    check32("scaled_re", s_re, 32'd69);
    check32("scaled_im", s_im, -32'sd3);
`else
    check32("scaled_re", s_re, 32'd68);
    check32("scaled_im", s_im, -32'sd4);
`endif
    check1("scaled_ovf", ovf, 1'b0);
    step();
    check1("scaled_drain", out_valid, 1'b0);

    // Unscaled positive saturation and sticky behaviour.
    send(1'b0, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0);
    step();
    check32("sat_pos_re", s_re, 32'h7FFF_FFFF);
    check32("sat_pos_im", s_im, 32'd0);
    check1("sat_pos_ovf", ovf, 1'b1);
    send(1'b0, 1'b0, 32'd1, 32'd4, 32'd2, 32'd3);
    step();
    check32("clean_re", s_re, 32'd3);
    check32("clean_im", s_im, 32'd7);
    check1("sticky_hold", ovf, 1'b1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check1("clr_ovf", ovf, 1'b0);

    // Negative saturation loaded in the same cycle as a clear: set wins.
    send(1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd1, 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check32("sat_neg_re", s_re, 32'h8000_0000);
    check1("set_beats_clr", ovf, 1'b1);
    check1("ns_ovf_pulse", ovf_ns, 1'b1);
    step();
    check1("ns_ovf_idle", ovf_ns, 1'b0);
    check1("sticky_after_drain", ovf, 1'b1);

    // Scaled subtract at the extreme: only rounding can clamp.
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    send(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd0);
    step();
    check32("scaled_extreme_re", s_re, 32'h7FFF_FFFF);
    check32("scaled_extreme_im", s_im, 32'd0);
`ifdef CSA_ROUND_EN
    check1("scaled_extreme_ovf", ovf, 1'b1);
`else
    check1("scaled_extreme_ovf", ovf, 1'b0);
`endif
    step();

    // Pulse-mode flag over alternating clamping / clean results.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        if (k % 2 == 0) set_in(1'b0, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd0);
        else            set_in(1'b0, 1'b0, 32'(k), 32'd0, 32'd1, 32'd0);
      end
      in_valid = (k < 4);
      step();
      if (k >= 1 && k <= 4) begin
        check1("ns_stream_valid", out_valid_ns, 1'b1);
        check1("ns_stream_ovf", ovf_ns, ((k - 1) % 2 == 0) ? 1'b1 : 1'b0);
        check32("ns_stream_re", s_re_ns,
                ((k - 1) % 2 == 0) ? 32'h7FFF_FFFF : 32'(k));
      end
    end
    in_valid = 1'b0;
    check1("ns_stream_end_valid", out_valid_ns, 1'b0);
    check1("ns_stream_end_ovf", ovf_ns, 1'b0);

    // Eight back-to-back inputs, consumer stalled for cycles 3..6.
    acc = 0; got = 0; held_v = 1'b0; held_re = '0; held_im = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid = (acc < 8);
      set_in(1'b0, 1'b0, 32'(10 + acc), 32'(-acc), 32'(acc), 32'd0);
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (acc < 8) check1("stall_in_ready", in_ready, (c >= 3 && c <= 6) ? 1'b0 : 1'b1);
      if (held_v) begin
        check1("stall_hold_valid", out_valid, 1'b1);
        check32("stall_hold_re", s_re, held_re);
        check32("stall_hold_im", s_im, held_im);
      end
      if (out_valid && out_ready) begin
        check32("stream_re", s_re, 32'(10 + 2 * got));
        check32("stream_im", s_im, 32'(-got));
        got++;
      end
      held_v  = out_valid && !out_ready;
      held_re = s_re;
      held_im = s_im;
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check32("stream_count", 32'(got), 32'd8);
    step();
    check1("stream_no_dup", out_valid, 1'b0);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 32'h7FFF_FFFF, 32'd9, 32'd1, 32'd1);
    in_valid = 1'b1;
    step();
    set_in(1'b0, 1'b0, 32'd2, 32'd2, 32'd2, 32'd2);
    step();
    in_valid = 1'b0;
    check1("pre_rst_valid", out_valid, 1'b1);
    check1("pre_rst_ovf", ovf, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_valid", out_valid, 1'b0);
    check32("async_rst_re", s_re, 32'd0);
    check32("async_rst_im", s_im, 32'd0);
    check1("async_rst_ovf", ovf, 1'b0);
    check1("async_rst_ovf_ns", ovf_ns, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check1("post_rst_no_stale1", out_valid, 1'b0);
    step();
    check1("post_rst_no_stale2", out_valid, 1'b0);
    send(1'b0, 1'b0, 32'd5, 32'd1, 32'd6, 32'd1);
    check1("post_rst_lat1", out_valid, 1'b0);
    step();
    check1("post_rst_lat2", out_valid, 1'b1);
    check32("post_rst_re", s_re, 32'd11);
    check32("post_rst_im", s_im, 32'd2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
